// File: rtl/micro_ucr_pkg.sv
// Shared types and helpers for the micro-UCR result-side checker.
package micro_ucr_pkg;

  localparam int HASH_W  = 24;
  localparam int NONCE_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_CHECK,
    ST_DONE,
    ST_ERROR
  } chk_state_t;

  // Only the two leading hash bytes take part in qualification.
  function automatic logic hash_qualifies(input logic [7:0] h0,
                                          input logic [7:0] h1,
                                          input logic [7:0] target);
    return (h0 < target) && (h1 < target);
  endfunction

endpackage

// File: rtl/micro_ucr_timeout_cnt.sv
// Clearable up-counter; tc flags the TIMEOUT-th enabled cycle since the last clear.
module micro_ucr_timeout_cnt #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt;

  assign tc = en && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (!reset)         cnt <= '0;
    else if (clr)       cnt <= '0;
    else if (en && !tc) cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/micro_ucr_hash_checker.sv
// Issues nonce candidates to the hash core, checks each result against TARGET
// and stops on the first qualifying nonce, nonce exhaustion or a core timeout.
module micro_ucr_hash_checker
  import micro_ucr_pkg::*;
#(
  parameter logic [7:0]         TARGET    = 8'h10,
  parameter logic [NONCE_W-1:0] NONCE_MAX = 32'hFFFF_FFFF,
  parameter int                 TIMEOUT   = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               go,
  input  logic [7:0]         hash_array0,
  input  logic [7:0]         hash_array1,
  input  logic [7:0]         hash_array2,
  input  logic               hash_valid,
  output logic               start,
  output logic [7:0]         nonce0,
  output logic [7:0]         nonce1,
  output logic [7:0]         nonce2,
  output logic [7:0]         nonce3,
  output logic               busy,
  output logic               found,
  output logic               timeout_err,
  output logic [NONCE_W-1:0] result_nonce,
  output logic [HASH_W-1:0]  result_hash
);

  chk_state_t         state;
  logic [NONCE_W-1:0] nonce;
  logic [HASH_W-1:0]  hash_q;
  logic               tmo;

  assign {nonce0, nonce1, nonce2, nonce3} = nonce;

  micro_ucr_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_tmo (
    .clk   (clk),
    .reset (reset),
    .clr   (state == ST_REQ),
    .en    (state == ST_WAIT),
    .tc    (tmo)
  );

  // Outputs are set on the transition into each state so they line up with it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= ST_IDLE;
      nonce        <= '0;
      hash_q       <= '0;
      start        <= 1'b0;
      busy         <= 1'b0;
      found        <= 1'b0;
      timeout_err  <= 1'b0;
      result_nonce <= '0;
      result_hash  <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (go) begin
            state       <= ST_REQ;
            nonce       <= '0;
            start       <= 1'b1;
            busy        <= 1'b1;
            found       <= 1'b0;
            timeout_err <= 1'b0;
          end
        end
        ST_REQ: begin
          start <= 1'b0;
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          // A valid arriving on the terminal cycle still wins.
          if (hash_valid) begin
            hash_q <= {hash_array0, hash_array1, hash_array2};
            state  <= ST_CHECK;
          end else if (tmo) begin
            busy        <= 1'b0;
            timeout_err <= 1'b1;
            state       <= ST_ERROR;
          end
        end
        ST_CHECK: begin
          if (hash_qualifies(hash_q[23:16], hash_q[15:8], TARGET)) begin
            result_nonce <= nonce;
            result_hash  <= hash_q;
            found        <= 1'b1;
            busy         <= 1'b0;
            state        <= ST_DONE;
          end else if (nonce == NONCE_MAX) begin
            busy  <= 1'b0;
            state <= ST_DONE;
          end else begin
            nonce <= nonce + 1'b1;
            start <= 1'b1;
            state <= ST_REQ;
          end
        end
        default: begin
          state <= ST_IDLE;
          start <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_micro_ucr_hash_checker.sv
// Directed bench: dut_a (TIMEOUT=8) covers search, boundary compare, timeout
// and reset; dut_b (NONCE_MAX=2) covers exhaustion.
module tb_micro_ucr_hash_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, go_a, go_b, hv_a, hv_b;
  logic [7:0] h0, h1, h2;

  logic        a_start, a_busy, a_found, a_terr;
  logic [7:0]  a_n0, a_n1, a_n2, a_n3;
  logic [31:0] a_rn;
  logic [23:0] a_rh;
  logic        b_start, b_busy, b_found, b_terr;
  logic [7:0]  b_n0, b_n1, b_n2, b_n3;
  logic [31:0] b_rn;
  logic [23:0] b_rh;

  int total = 0;
  int bad   = 0;

  micro_ucr_hash_checker #(.TARGET(8'h10), .NONCE_MAX(32'h10), .TIMEOUT(8)) dut_a (
    .clk(clk), .reset(reset), .go(go_a),
    .hash_array0(h0), .hash_array1(h1), .hash_array2(h2), .hash_valid(hv_a),
    .start(a_start), .nonce0(a_n0), .nonce1(a_n1), .nonce2(a_n2), .nonce3(a_n3),
    .busy(a_busy), .found(a_found), .timeout_err(a_terr),
    .result_nonce(a_rn), .result_hash(a_rh)
  );

  micro_ucr_hash_checker #(.TARGET(8'h10), .NONCE_MAX(32'h2), .TIMEOUT(8)) dut_b (
    .clk(clk), .reset(reset), .go(go_b),
    .hash_array0(h0), .hash_array1(h1), .hash_array2(h2), .hash_valid(hv_b),
    .start(b_start), .nonce0(b_n0), .nonce1(b_n1), .nonce2(b_n2), .nonce3(b_n3),
    .busy(b_busy), .found(b_found), .timeout_err(b_terr),
    .result_nonce(b_rn), .result_hash(b_rh)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_rst(input string tag);
    check({tag, "_a_start"}, 32'(a_start), 32'h0);
    check({tag, "_a_busy"},  32'(a_busy),  32'h0);
    check({tag, "_a_found"}, 32'(a_found), 32'h0);
    check({tag, "_a_terr"},  32'(a_terr),  32'h0);
    check({tag, "_a_nonce"}, {a_n0, a_n1, a_n2, a_n3}, 32'h0);
    check({tag, "_a_rn"},    a_rn, 32'h0);
    check({tag, "_a_rh"},    32'(a_rh), 32'h0);
    check({tag, "_b_outs"},  32'({b_start, b_busy, b_found, b_terr}), 32'h0);
  endtask

  // Core responder: valid one cycle after each start; nonce 3 gives 05,0A,77 in mode 1.
  task automatic serve(input bit sel, input int mode, output int n, output bit ok);
    int pend;
    logic [31:0] cur;
    logic st, bz;
    n = 0; ok = 1'b0; pend = 0; cur = '0;
    for (int c = 0; c < 300; c++) begin
      st = sel ? b_start : a_start;
      bz = sel ? b_busy  : a_busy;
      hv_a = 1'b0; hv_b = 1'b0;
      if (!bz) begin ok = 1'b1; break; end
      if (st) begin
        n++;
        cur  = sel ? {b_n0, b_n1, b_n2, b_n3} : {a_n0, a_n1, a_n2, a_n3};
        pend = 1;
      end else if (pend != 0) begin
        pend = 0;
        if (sel) hv_b = 1'b1; else hv_a = 1'b1;
        {h0, h1, h2} = (mode == 1 && cur == 32'h3) ? 24'h050A77 : 24'hFFFFFF;
      end
      @(negedge clk);
    end
  endtask

  int  nst;
  bit  ok;

  initial begin
    reset = 1'b0; go_a = 1'b0; go_b = 1'b0; hv_a = 1'b0; hv_b = 1'b0;
    h0 = '0; h1 = '0; h2 = '0;

    // Reset held two cycles.
    @(negedge clk); check_rst("rst1");
    @(negedge clk); check_rst("rst2");
    reset = 1'b1;

    // Search: nonce 3 qualifies.
    go_a = 1'b1;
    @(negedge clk); go_a = 1'b0;
    check("go_start", 32'(a_start), 32'h1);
    check("go_nonce", {a_n0, a_n1, a_n2, a_n3}, 32'h0);
    check("go_busy",  32'(a_busy), 32'h1);
    serve(1'b0, 1, nst, ok);
    check("srch_done",   32'(ok), 32'h1);
    check("srch_starts", nst, 32'd4);
    check("srch_found",  32'(a_found), 32'h1);
    check("srch_rn",     a_rn, 32'h3);
    check("srch_rh",     32'(a_rh), 32'h050A77);
    check("srch_busy",   32'(a_busy), 32'h0);

    // Boundary compare with exact cycle timing; stray valid and go in REQ.
    go_a = 1'b1;
    @(negedge clk); go_a = 1'b0;                       // S: REQ
    check("bnd_start0", 32'(a_start), 32'h1);
    check("bnd_fclr",   32'(a_found), 32'h0);
    @(negedge clk); hv_a = 1'b1; {h0, h1, h2} = 24'h1000AA;  // S+1: WAIT
    @(negedge clk); hv_a = 1'b0;                       // S+2: CHECK
    check("bnd_chk_busy",  32'(a_busy),  32'h1);
    check("bnd_chk_start", 32'(a_start), 32'h0);
    @(negedge clk);                                    // S+3: REQ nonce 1
    check("bnd_rej_start", 32'(a_start), 32'h1);
    check("bnd_rej_nonce", {a_n0, a_n1, a_n2, a_n3}, 32'h1);
    hv_a = 1'b1; go_a = 1'b1; {h0, h1, h2} = 24'h0000EE;
    @(negedge clk); go_a = 1'b0;                       // S+4: WAIT
    check("ign_busy",  32'(a_busy),  32'h1);
    check("ign_start", 32'(a_start), 32'h0);
    check("ign_nonce", {a_n0, a_n1, a_n2, a_n3}, 32'h1);
    hv_a = 1'b1; {h0, h1, h2} = 24'h0F0F33;
    @(negedge clk); hv_a = 1'b0;                       // S+5: CHECK
    check("acc_chk_found", 32'(a_found), 32'h0);
    check("acc_chk_busy",  32'(a_busy),  32'h1);
    @(negedge clk);                                    // S+6: DONE
    check("acc_found", 32'(a_found), 32'h1);
    check("acc_busy",  32'(a_busy),  32'h0);
    check("acc_rn",    a_rn, 32'h1);
    check("acc_rh",    32'(a_rh), 32'h0F0F33);

    // Timeout: silent core, TIMEOUT=8.
    go_a = 1'b1;
    @(negedge clk); go_a = 1'b0;
    check("tmo_start", 32'(a_start), 32'h1);
    repeat (8) @(negedge clk);
    check("tmo_pre_err",  32'(a_terr), 32'h0);
    check("tmo_pre_busy", 32'(a_busy), 32'h1);
    @(negedge clk);
    check("tmo_err",  32'(a_terr), 32'h1);
    check("tmo_busy", 32'(a_busy), 32'h0);
    go_a = 1'b1;
    @(negedge clk); go_a = 1'b0;
    check("tmo_clr",   32'(a_terr), 32'h0);
    check("tmo_rst_start", 32'(a_start), 32'h1);
    check("tmo_rst_nonce", {a_n0, a_n1, a_n2, a_n3}, 32'h0);

    // Reset dropped mid-WAIT.
    @(negedge clk); reset = 1'b0;
    @(negedge clk); check_rst("midrst");
    reset = 1'b1;

    // Exhaustion on dut_b.
    go_b = 1'b1;
    @(negedge clk); go_b = 1'b0;
    serve(1'b1, 0, nst, ok);
    check("exh_done",   32'(ok), 32'h1);
    check("exh_starts", nst, 32'd3);
    check("exh_found",  32'(b_found), 32'h0);
    check("exh_busy",   32'(b_busy),  32'h0);
    check("exh_nonce",  {b_n0, b_n1, b_n2, b_n3}, 32'h2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/micro_ucr_hash_checker.md
# micro_ucr_hash_checker

Result-side controller for the micro-UCR hash core. It issues nonce candidates to the core and captures the 24-bit result (`hash_array0..2`) under a valid/timeout handshake. It compares each result against a target threshold and stops on the first qualifying nonce or when the nonce space is exhausted. It sits between the core's output and the system's status/registers, and drives only the nonce bytes (`array_numbers12..15`) of the core input.

## Interface
Parameters:
- `TARGET`, 8'h10: a hash qualifies iff `hash_array0 < TARGET` and `hash_array1 < TARGET` (unsigned).
- `NONCE_MAX`, 32'hFFFF_FFFF: last nonce tried before declaring exhaustion.
- `TIMEOUT`, 64: maximum cycles to wait for `hash_valid` after `start`.

Ports:
- `clk` in 1: single clock, all logic on posedge.
- `reset` in 1: synchronous, active-low; sampled on posedge `clk`.
- `go` in 1: begin a search from nonce 0; honoured only in IDLE, DONE or ERROR.
- `hash_array0..2` in 8 each: hash result bytes from the core.
- `hash_valid` in 1: core result valid; one-cycle pulse.
- `start` out 1: one-cycle pulse telling the core to hash the current nonce.
- `nonce0..3` out 8 each: current nonce, big-endian (`nonce0` = bits 31:24); feeds `array_numbers12..15`.
- `busy` out 1: high in REQ, WAIT and CHECK.
- `found` out 1: high in DONE when a qualifying nonce was found.
- `timeout_err` out 1: high in ERROR.
- `result_nonce` out 32: winning nonce, valid while `found`.
- `result_hash` out 24: `{hash_array0, hash_array1, hash_array2}` captured for the winning nonce.

## Operation
States: IDLE, REQ, WAIT, CHECK, DONE, ERROR.
- **IDLE**: `go` → REQ with nonce := 0.
- **REQ**: assert `start` for exactly this cycle; clear the timeout counter; → WAIT.
- **WAIT**: count cycles.
  - `hash_valid` → capture the three bytes into the hash register; → CHECK.
  - Counter reaches `TIMEOUT` with no valid → ERROR.
- **CHECK**: evaluate the qualifying condition on the captured bytes.
  - Qualifies → latch `result_nonce` and `result_hash`; → DONE with `found`=1.
  - Fails and nonce == `NONCE_MAX` → DONE with `found`=0.
  - Fails otherwise → nonce+1 (32-bit, no wrap possible given the previous rule); → REQ.
- **DONE / ERROR**: hold all outputs; `go` restarts at nonce 0, clears `found`/`timeout_err` and → REQ.
- `hash_valid` outside WAIT is ignored and not buffered.
- `hash_valid` in the same cycle the counter reaches `TIMEOUT`: valid wins → CHECK.
- `go` while busy is ignored.
- Comparison is strict less-than. `hash_array2` does not participate in qualification, only in `result_hash`.

## Timing
- Reset values:
  - all outputs 0: `start`, `busy`, `found`, `timeout_err`, `nonce0..3`, `result_nonce`, `result_hash`.
  - state IDLE; internal counter and hash register 0.
- Reset asserted mid-search takes effect at the next posedge and aborts with no further `start`.
- `go` sampled high in cycle N → `start` high in cycle N+1.
- `nonce0..3` are stable from the `start` cycle until the CHECK exit cycle.
- Per-nonce loop: REQ(1) + WAIT(k ≥ 1) + CHECK(1) = k+2 cycles.
- `hash_valid` in cycle M → CHECK in M+1 → `found` or next `start` visible in M+2.
- Timeout: valid absent for `TIMEOUT` cycles after `start` → `timeout_err` high in the following cycle.

## Structure
- Shared package `micro_ucr_pkg` holds:
  - state enum `chk_state_t`;
  - `HASH_W`=24 and `NONCE_W`=32;
  - a pure function `hash_qualifies(h0, h1, target)`.
- One sub-module, `micro_ucr_timeout_cnt`: a clearable up-counter with terminal-count flag, parameterized by `TIMEOUT`.
- Nonce, FSM and result registers live in the top.

## Test plan
- Reset held low 2 cycles, then `go`: `start` rises the cycle after `go`, `nonce0..3`=00,00,00,00, `busy`=1; all outputs were 0 during reset.
- Responder model returns `hash_array0..2`=8'h05, 8'h0A, 8'h77 for nonce 3 and 8'hFF,… otherwise:
  - `found`=1, `result_nonce`=32'h3, `result_hash`=24'h050A77;
  - exactly 4 `start` pulses issued.
- Boundary compare: hash 8'h10, 8'h00 → rejected; hash 8'h0F, 8'h0F → accepted.
- `NONCE_MAX`=2 and no hash ever qualifies: 3 `start` pulses, then DONE with `found`=0, `busy`=0.
- Core silent after `start` with `TIMEOUT`=8: `timeout_err`=1 on cycle 9 after `start`; a following `go` clears it and restarts at nonce 0.
- Extra `hash_valid` pulse during REQ plus `go` pulses while busy: both ignored, nonce sequence unchanged; reset dropped mid-WAIT returns everything to reset values on the next edge.
